// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OPCODE,
      ST_PAYLOAD,
      ST_DISCARD
   } state_t;

   localparam int PKG_OPCODE_W = 4;
   localparam int PKG_LEN_W    = 6;
   localparam int PKG_NUM_OPS  = 2**PKG_OPCODE_W;

   localparam logic [PKG_OPCODE_W-1:0] OP_VALID_MOVE = 4'd0;
   localparam logic [PKG_OPCODE_W-1:0] OP_STATUS     = 4'd1;
   localparam logic [PKG_OPCODE_W-1:0] OP_WORD       = 4'd2;
   localparam logic [PKG_OPCODE_W-1:0] OP_BYTE       = 4'd3;

   localparam logic [PKG_LEN_W-1:0] LEN_VALID_MOVE = 6'd10;
   localparam logic [PKG_LEN_W-1:0] LEN_STATUS     = 6'd0;
   localparam logic [PKG_LEN_W-1:0] LEN_WORD       = 6'd32;
   localparam logic [PKG_LEN_W-1:0] LEN_BYTE       = 6'd8;
   localparam logic [PKG_LEN_W-1:0] LEN_DEFAULT    = 6'd16;

   function automatic logic [PKG_NUM_OPS*PKG_LEN_W-1:0] default_len_table();
      logic [PKG_NUM_OPS*PKG_LEN_W-1:0] t;
      for (int k = 0; k < PKG_NUM_OPS; k++) t[k*PKG_LEN_W +: PKG_LEN_W] = LEN_DEFAULT;
      t[int'(OP_VALID_MOVE)*PKG_LEN_W +: PKG_LEN_W] = LEN_VALID_MOVE;
      t[int'(OP_STATUS)*PKG_LEN_W +: PKG_LEN_W]     = LEN_STATUS;
      t[int'(OP_WORD)*PKG_LEN_W +: PKG_LEN_W]       = LEN_WORD;
      t[int'(OP_BYTE)*PKG_LEN_W +: PKG_LEN_W]       = LEN_BYTE;
      return t;
   endfunction

endpackage

// File: rtl/serial_frame_rx_sync.sv
// Synchroniser for the link clock/data with a post-reset edge mask and
// a one-cycle rising-edge strobe.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_ser_clk,
   input  logic i_ser_data,
   output logic o_edge,
   output logic o_bit
);

   localparam int MASK_CYC = SYNC_STAGES + 1;
   localparam int MASK_W   = $clog2(MASK_CYC + 1);

   logic [SYNC_STAGES-1:0] r_csync;
   logic [SYNC_STAGES-1:0] r_dsync;
   logic                   r_cprev;
   logic [MASK_W-1:0]      r_mask;
   logic                   w_armed;

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_csync <= '0;
         r_dsync <= '0;
         r_cprev <= 1'b0;
         r_mask  <= '0;
      end else begin
         r_csync <= {r_csync[SYNC_STAGES-2:0], i_ser_clk};
         r_dsync <= {r_dsync[SYNC_STAGES-2:0], i_ser_data};
         r_cprev <= r_csync[SYNC_STAGES-1];
         if (!w_armed) r_mask <= r_mask + 1'b1;
      end
   end

   // A link clock already high at reset release must not look like an edge.
   assign w_armed = (r_mask == MASK_W'(MASK_CYC));
   assign o_edge  = r_csync[SYNC_STAGES-1] & ~r_cprev & w_armed;
   assign o_bit   = r_dsync[SYNC_STAGES-1];

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: opcode + table-driven payload length, delivered
// on a valid/ready output register with a polled toggle flag.
module serial_frame_rx
   import serial_frame_pkg::*;
#(
   parameter int OPCODE_W       = 4,
   parameter int DATA_W         = 32,
   parameter int LEN_W          = 6,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                          i_clock,
   input  logic                          i_reset_n,
   input  logic                          i_ser_clk,
   input  logic                          i_ser_data,
   input  logic [(2**OPCODE_W)*LEN_W-1:0] i_len_table,
   output logic                          o_data_out,
   output logic                          o_clock_out,
   output logic                          o_frame_valid,
   input  logic                          i_frame_ready,
   output logic [OPCODE_W-1:0]           o_frame_opcode,
   output logic [LEN_W-1:0]              o_frame_len,
   output logic [DATA_W-1:0]             o_frame_data,
   output logic                          o_toggle,
   output logic                          o_err_timeout,
   output logic                          o_err_badop,
   output logic                          o_err_overrun
);

   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);

   logic w_edge, w_bit;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clock    (i_clock),
      .i_reset_n  (i_reset_n),
      .i_ser_clk  (i_ser_clk),
      .i_ser_data (i_ser_data),
      .o_edge     (w_edge),
      .o_bit      (w_bit)
   );

   assign o_data_out  = i_ser_data;
   assign o_clock_out = i_ser_clk;

   logic [LEN_W-1:0] w_len_lut [2**OPCODE_W];
   for (genvar k = 0; k < 2**OPCODE_W; k++) begin : g_lut
      assign w_len_lut[k] = i_len_table[k*LEN_W +: LEN_W];
   end

   state_t            r_state, w_state_nxt;
   logic [OPCODE_W-1:0] r_opcode, w_op_shift, w_done_op;
   logic [LEN_W-1:0]  r_len, r_cnt, w_lut_len, w_done_len;
   logic [DATA_W-1:0] r_shift, w_data_shift, w_done_data;
   logic [IDLE_W-1:0] r_idle;
   logic w_op_last, w_pl_last, w_idle_exp;
   logic w_done, w_badop, w_tmo, w_load, w_overrun;

   assign w_op_shift   = (r_state == ST_IDLE) ? {{(OPCODE_W-1){1'b0}}, w_bit}
                                              : {r_opcode[OPCODE_W-2:0], w_bit};
   assign w_lut_len    = w_len_lut[w_op_shift];
   assign w_data_shift = {r_shift[DATA_W-2:0], w_bit};
   assign w_op_last    = w_edge && (r_state == ST_OPCODE) && (r_cnt == LEN_W'(OPCODE_W-1));
   assign w_pl_last    = w_edge && (r_cnt == r_len - 1'b1);
   assign w_idle_exp   = !w_edge && (r_state != ST_IDLE) &&
                         (r_idle == IDLE_W'(TIMEOUT_CYCLES-1));

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      w_badop     = 1'b0;
      w_tmo       = 1'b0;
      w_done_op   = r_opcode;
      w_done_len  = r_len;
      w_done_data = w_data_shift;
      case (r_state)
         ST_IDLE:    if (w_edge) w_state_nxt = ST_OPCODE;
         ST_OPCODE: begin
            if (w_op_last) begin
               w_done_op   = w_op_shift;
               w_done_len  = w_lut_len;
               w_done_data = '0;
               if (w_lut_len == '0) begin
                  w_done      = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else if (int'(w_lut_len) <= DATA_W) begin
                  w_state_nxt = ST_PAYLOAD;
               end else begin
                  w_badop     = 1'b1;
                  w_state_nxt = ST_DISCARD;
               end
            end
         end
         ST_PAYLOAD: if (w_pl_last) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         ST_DISCARD: if (w_pl_last) w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
      // Expiry only fires on edge-free cycles, so it never meets a frame load.
      if (w_idle_exp) begin
         w_tmo       = 1'b1;
         w_state_nxt = ST_IDLE;
      end
   end

   assign w_load    = w_done && (!o_frame_valid || i_frame_ready);
   assign w_overrun = w_done && o_frame_valid && !i_frame_ready;

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) r_state <= ST_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_opcode       <= '0;
         r_len          <= '0;
         r_cnt          <= '0;
         r_shift        <= '0;
         r_idle         <= '0;
         o_frame_valid  <= 1'b0;
         o_frame_opcode <= '0;
         o_frame_len    <= '0;
         o_frame_data   <= '0;
         o_toggle       <= 1'b0;
         o_err_timeout  <= 1'b0;
         o_err_badop    <= 1'b0;
         o_err_overrun  <= 1'b0;
      end else begin
         if (w_edge || r_state == ST_IDLE || w_idle_exp) r_idle <= '0;
         else                                            r_idle <= r_idle + 1'b1;

         if (w_edge) begin
            case (r_state)
               ST_IDLE: begin
                  r_opcode <= w_op_shift;
                  r_cnt    <= LEN_W'(1);
               end
               ST_OPCODE: begin
                  r_opcode <= w_op_shift;
                  if (w_op_last) begin
                     r_cnt   <= '0;
                     r_len   <= w_lut_len;
                     r_shift <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               ST_PAYLOAD: begin
                  r_shift <= w_data_shift;
                  r_cnt   <= r_cnt + 1'b1;
               end
               ST_DISCARD: r_cnt <= r_cnt + 1'b1;
               default: ;
            endcase
         end

         o_err_timeout <= w_tmo;
         o_err_badop   <= w_badop;
         o_err_overrun <= w_overrun;

         if (w_load) begin
            o_frame_valid  <= 1'b1;
            o_frame_opcode <= w_done_op;
            o_frame_len    <= w_done_len;
            o_frame_data   <= w_done_data;
            o_toggle       <= ~o_toggle;
         end else if (i_frame_ready) begin
            o_frame_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with hand-computed expectations.
module tb_serial_frame_rx;
   import serial_frame_pkg::*;

   localparam int SYNC  = 2;
   localparam int TMO   = 4096;

   logic        clk = 1'b0;
   logic        rst_n, ser_clk, ser_data, ready;
   logic [95:0] len_table;
   logic        data_out, clock_out, valid, toggle;
   logic        err_tmo, err_bad, err_ovr;
   logic [3:0]  f_op;
   logic [5:0]  f_len;
   logic [31:0] f_data;

   int n_vec = 0, n_miss = 0;
   int c_tmo = 0, c_bad = 0, c_ovr = 0;

   serial_frame_rx #(.OPCODE_W(4), .DATA_W(32), .LEN_W(6), .SYNC_STAGES(SYNC),
                     .TIMEOUT_CYCLES(TMO)) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_ser_clk(ser_clk), .i_ser_data(ser_data),
      .i_len_table(len_table), .o_data_out(data_out), .o_clock_out(clock_out),
      .o_frame_valid(valid), .i_frame_ready(ready), .o_frame_opcode(f_op),
      .o_frame_len(f_len), .o_frame_data(f_data), .o_toggle(toggle),
      .o_err_timeout(err_tmo), .o_err_badop(err_bad), .o_err_overrun(err_ovr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (err_tmo) c_tmo++;
      if (err_bad) c_bad++;
      if (err_ovr) c_ovr++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      ser_data = b;
      repeat (4) tick();
      ser_clk = 1'b1;
      repeat (4) tick();
      ser_clk = 1'b0;
   endtask

   task automatic send_frame(input logic [3:0] op, input int len, input logic [39:0] pl);
      for (int i = 3; i >= 0; i--) send_bit(op[i]);
      for (int i = len - 1; i >= 0; i--) send_bit(pl[i]);
   endtask

   task automatic accept();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check("accept_clr", valid, 0);
   endtask

   initial begin
      int n;
      logic [9:0] pl;
      rst_n = 1'b0; ser_clk = 1'b0; ser_data = 1'b0; ready = 1'b0;
      len_table = default_len_table();
      repeat (3) tick();
      check("rst_valid", valid, 0);
      check("rst_toggle", toggle, 0);
      check("rst_data", f_data, 0);
      check("rst_oplen", {f_op, f_len}, 0);
      check("rst_errs", {err_tmo, err_bad, err_ovr}, 0);
      ser_data = 1'b1;
      #1 check("pass_data", data_out, 1);
      check("pass_clk", clock_out, 0);
      ser_data = 1'b0;
      rst_n = 1'b1;
      repeat (6) tick();

      // basic frame
      send_frame(4'd0, 10, 40'h2CE);
      check("basic_valid", valid, 1);
      check("basic_op", f_op, 0);
      check("basic_len", f_len, 10);
      check("basic_data", f_data, 32'h0000_02CE);
      check("basic_toggle", toggle, 1);
      accept();

      // overrun: second frame arrives while first is still held
      send_frame(4'd2, 32, 40'hDEAD_BEEF);
      check("ovr_toggle1", toggle, 0);
      send_frame(4'd1, 0, 40'h0);
      check("ovr_pulses", c_ovr, 1);
      check("ovr_valid", valid, 1);
      check("ovr_op", f_op, 2);
      check("ovr_len", f_len, 32);
      check("ovr_data", f_data, 32'hDEAD_BEEF);
      check("ovr_toggle2", toggle, 0);
      accept();

      // timeout after two opcode bits
      send_bit(1'b1);
      ser_data = 1'b0;
      repeat (4) tick();
      ser_clk = 1'b1;
      n = 0;
      while (n < TMO + 100) begin
         tick();
         n++;
         if (n == 4) ser_clk = 1'b0;
         if (err_tmo) break;
      end
      check("tmo_latency", n, SYNC + 1 + TMO);
      tick();
      check("tmo_width", err_tmo, 0);
      check("tmo_pulses", c_tmo, 1);
      check("tmo_noload", valid, 0);
      send_frame(4'd0, 10, 40'h3E0);
      check("tmo_next_data", f_data, 32'h3E0);
      check("tmo_next_toggle", toggle, 1);
      accept();

      // bad length
      len_table[3*6 +: 6] = 6'd40;
      send_frame(4'd3, 40, 40'hA5_A5A5_A5A5);
      check("bad_pulses", c_bad, 1);
      check("bad_noload", valid, 0);
      check("bad_toggle", toggle, 1);
      send_frame(4'd0, 10, 40'h001);
      check("bad_next_valid", valid, 1);
      check("bad_next_data", f_data, 32'h1);
      check("bad_next_toggle", toggle, 0);

      // reset during payload bit 5, link clock high across reset release
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      ser_data = 1'b1;
      repeat (4) tick();
      ser_clk = 1'b1;
      tick(); tick();
      rst_n = 1'b0;
      tick(); tick();
      check("mrst_valid", valid, 0);
      check("mrst_toggle", toggle, 0);
      check("mrst_data", f_data, 0);
      check("mrst_oplen", {f_op, f_len}, 0);
      rst_n = 1'b1;
      repeat (4) tick();
      ser_clk = 1'b0;
      repeat (6) tick();
      check("mrst_errs", {c_tmo[7:0], c_bad[7:0], c_ovr[7:0]}, 32'h010101);
      send_frame(4'd0, 10, 40'h201);
      check("mrst_next_data", f_data, 32'h201);
      check("mrst_next_toggle", toggle, 1);

      // accept of held frame in the very cycle the next frame loads
      pl = 10'h155;
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      for (int i = 9; i >= 1; i--) send_bit(pl[i]);
      ser_data = pl[0];
      repeat (4) tick();
      ser_clk = 1'b1;
      tick(); tick();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check("sim_valid", valid, 1);
      check("sim_data", f_data, 32'h155);
      check("sim_len", f_len, 10);
      check("sim_toggle", toggle, 0);
      repeat (3) tick();
      ser_clk = 1'b0;
      tick();
      check("sim_no_ovr", c_ovr, 1);
      accept();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
